// File: rtl/fib_seq_ctrl_pkg.sv
// fib_seq_ctrl_pkg: ALU opcodes and sequencer state encoding shared by the Fibonacci block
package fib_seq_ctrl_pkg;
  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_SET  = 3'b001,
    OP_INC  = 3'b010,
    OP_DEC  = 3'b011,
    OP_LOAD = 3'b101,
    OP_ADD  = 3'b110,
    OP_COPY = 3'b111
  } opcode_e;
  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_N,
    S_CHK_N,
    S_SET_C,
    S_DEC,
    S_CHK,
    S_ADD,
    S_COPY,
    S_MOVE,
    S_DONE
  } state_e;
endpackage

// File: rtl/fib_seq_ctrl_alu.sv
// fib_seq_ctrl_alu: shared 3-bit-opcode ALU; zero_flag reports A==0
module fib_seq_ctrl_alu
  import fib_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [2:0]       opcode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] o_o,
  output logic             zero_flag_o
);
  localparam logic [WIDTH-1:0] ONE = 1;
  always_comb begin
    o_o = '1;
    case (opcode_i)
      OP_SET:  o_o = ONE;
      OP_INC:  o_o = a_i + ONE;
      OP_DEC:  o_o = a_i - ONE;
      OP_LOAD: o_o = a_i;
      OP_ADD:  o_o = a_i + b_i;
      OP_COPY: o_o = b_i;
      default: o_o = '1;
    endcase
  end
  assign zero_flag_o = a_i == '0;
endmodule

// File: rtl/fib_seq_ctrl.sv
// fib_seq_ctrl: sequences the shared ALU one op per cycle to compute F(n) mod 2^WIDTH
module fib_seq_ctrl
  import fib_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] n_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic [2:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_o,
  input  logic             alu_zero
);
  state_e state_q, state_d;
  opcode_e op;
  logic [WIDTH-1:0] cnt_q, cnt_d, prev_q, prev_d, curr_q, curr_d, tmp_q, tmp_d, result_q, result_d;
  logic ovf_q, ovf_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      prev_q   <= '0;
      curr_q   <= '0;
      tmp_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
      curr_q   <= curr_d;
      tmp_q    <= tmp_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prev_d   = prev_q;
    curr_d   = curr_q;
    tmp_d    = tmp_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    op       = OP_NOP;
    alu_a    = '0;
    alu_b    = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          prev_d  = '0;
          ovf_d   = 1'b0;
          state_d = S_LOAD_N;
        end
      end
      S_LOAD_N: begin
        op      = OP_LOAD;
        alu_a   = n_in;
        cnt_d   = alu_o;
        state_d = S_CHK_N;
      end
      S_CHK_N: begin
        alu_a    = cnt_q;
        result_d = alu_zero ? prev_q : result_q;
        state_d  = alu_zero ? S_DONE : S_SET_C;
      end
      S_SET_C: begin
        op      = OP_SET;
        curr_d  = alu_o;
        state_d = S_DEC;
      end
      S_DEC: begin
        op      = OP_DEC;
        alu_a   = cnt_q;
        cnt_d   = alu_o;
        state_d = S_CHK;
      end
      S_CHK: begin
        alu_a    = cnt_q;
        result_d = alu_zero ? curr_q : result_q;
        state_d  = alu_zero ? S_DONE : S_ADD;
      end
      S_ADD: begin
        // a wrapped sum is always smaller than either operand
        op      = OP_ADD;
        alu_a   = prev_q;
        alu_b   = curr_q;
        tmp_d   = alu_o;
        ovf_d   = ovf_q | (alu_o < curr_q);
        state_d = S_COPY;
      end
      S_COPY: begin
        op      = OP_COPY;
        alu_b   = curr_q;
        prev_d  = alu_o;
        state_d = S_MOVE;
      end
      S_MOVE: begin
        op      = OP_LOAD;
        alu_a   = tmp_q;
        curr_d  = alu_o;
        state_d = S_DEC;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  assign alu_opcode = op;
  assign busy       = state_q != S_IDLE;
  assign done       = state_q == S_DONE;
  assign result     = result_q;
  assign ovf        = ovf_q;
endmodule

// File: tb/tb_fib_seq_ctrl.sv
// tb_fib_seq_ctrl: directed runs of the sequencer paired with the ALU, checked against a Fibonacci model
module tb_fib_seq_ctrl;
  localparam int WIDTH = 4;
  localparam int MOD = 1 << WIDTH;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [WIDTH-1:0] n_in = '0;
  logic busy, done, ovf, alu_zero;
  logic [WIDTH-1:0] result, alu_a, alu_b, alu_o;
  logic [2:0] alu_opcode;
  int checks = 0, errors = 0;

  fib_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_in(n_in),
    .busy(busy), .done(done), .result(result), .ovf(ovf),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_o(alu_o), .alu_zero(alu_zero)
  );
  fib_seq_ctrl_alu #(.WIDTH(WIDTH)) u_alu (
    .opcode_i(alu_opcode), .a_i(alu_a), .b_i(alu_b),
    .o_o(alu_o), .zero_flag_o(alu_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_ne(input string name, input int act, input int prev);
    checks++;
    if (act == prev) begin
      errors++;
      $display("FAIL %s actual=%0d required!=%0d at %0t", name, act, prev, $time);
    end
  endtask

  // F(n) mod 2^WIDTH, built from n-1 wrapping additions
  function automatic int fib_val(input int n);
    int a = 0, b = 1, t;
    if (n == 0) return 0;
    for (int i = 1; i < n; i++) begin
      t = a + b;
      a = b;
      b = t % MOD;
    end
    return b;
  endfunction

  function automatic int fib_ovf(input int n);
    int a = 0, b = 1, t, w = 0;
    for (int i = 1; i < n; i++) begin
      t = a + b;
      if (t >= MOD) w = 1;
      a = b;
      b = t % MOD;
    end
    return w;
  endfunction

  function automatic int lat_of(input int n);
    return n == 0 ? 3 : 5 * n + 1;
  endfunction

  // model: run flag, cycle index within the run, expected latency and outputs
  int m_cnt = 0, m_lat = 0, m_n = 0, m_res = 0, m_ovf = 0;
  bit m_run = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 0; m_cnt <= 0; m_lat <= 0; m_res <= 0; m_ovf <= 0;
    end else if (m_run) begin
      if (m_cnt == m_lat) m_run <= 0;
      else begin
        if (m_cnt == 1) begin
          m_n   <= int'(n_in);
          m_lat <= lat_of(int'(n_in));
        end
        m_cnt <= m_cnt + 1;
        if (m_cnt + 1 == m_lat) begin
          m_res <= fib_val(m_n);
          m_ovf <= fib_ovf(m_n);
        end
      end
    end else if (start) begin
      m_run <= 1; m_cnt <= 1; m_lat <= 0; m_ovf <= 0;
    end
  end

  bit p_act = 0;
  logic [2:0] p_op = '0;
  always @(negedge clk) begin
    bit act;
    bit m_done;
    m_done = m_run && m_cnt == m_lat;
    chk("busy", int'(busy), int'(m_run));
    chk("done", int'(done), int'(m_done));
    chk("result", int'(result), m_res);
    if (!m_run || m_done) chk("ovf", int'(ovf), m_ovf);
    if (!busy) begin
      chk("idle_op", int'(alu_opcode), 0);
      chk("idle_ab", int'({alu_a, alu_b}), 0);
    end
    act = busy && !done;
    if (act && p_act) chk_ne("op_change", int'(alu_opcode), int'(p_op));
    p_act = act && rst_n;
    p_op  = alu_opcode;
  end

  task automatic run(input int n, input int exp_res, input int exp_ovf, input int exp_lat);
    int c = 0;
    @(negedge clk);
    n_in  = WIDTH'(n);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    do begin
      @(negedge clk);
      c++;
    end while (!done && c < 200);
    chk($sformatf("lat_n%0d", n), c, exp_lat);
    chk($sformatf("res_n%0d", n), int'(result), exp_res);
    chk($sformatf("ovf_n%0d", n), int'(ovf), exp_ovf);
  endtask

  initial begin
    int dones;
    chk("pin_fib7", fib_val(7), 13);
    chk("pin_fib8", fib_val(8), 5);
    chk("pin_ovf7", fib_ovf(7), 0);
    chk("pin_ovf8", fib_ovf(8), 1);
    chk("pin_lat5", lat_of(5), 26);
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_result", int'(result), 0);
    rst_n = 1'b1;
    // reset mid-run, then a clean rerun
    @(negedge clk);
    n_in = 4'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_result", int'(result), 0);
    chk("mid_rst_ovf", int'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(5, 5, 0, 26);
    run(0, 0, 0, 3);
    run(1, 1, 0, 6);
    run(7, 13, 0, 36);
    run(2, 1, 0, 11);
    run(8, 5, 1, 41);
    repeat (3) @(negedge clk);
    chk("result_held", int'(result), 5);
    chk("ovf_held", int'(ovf), 1);
    run(3, 2, 0, 16);
    run(15, 2, 1, 76);
    // start hammered during an n=4 run; n_in disturbed after it was loaded
    @(negedge clk);
    n_in = 4'd4; start = 1'b1; dones = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        start = 1'b0;
      end
      if (c == 2) n_in = 4'd9;
    end
    start = 1'b0;
    chk("hammer_dones", dones, 1);
    chk("hammer_result", int'(result), 3);
    chk("hammer_ovf", int'(ovf), 0);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
